// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the 4:1 TDM word mux/demux path: FSM state encoding,
// lane count, slot-index constants and a slot-to-strobe helper.
package tdm_demux_pkg;

  typedef enum logic {
    StHunt = 1'b0,
    StLock = 1'b1
  } state_e;

  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned NUM_LANES = 4;

  localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

  // One-hot lane strobe for a slot index.
  function automatic logic [NUM_LANES-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    logic [NUM_LANES-1:0] one;
    one = {{(NUM_LANES-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demux: 2-bit wrap-around counter with a
// load-to-slot-1 (taken when a start-of-frame word is accepted into slot 0)
// and synchronous active-high clear.
module tdm_slot_counter
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load1,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_q;

  // Load beats increment: an SOF word always realigns the next slot to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT0;
    end else if (load1) begin
      slot_q <= SLOT1;
    end else if (inc) begin
      slot_q <= slot_q + 1'b1;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM word demultiplexer. Recovers the slot index from a start-of-frame
// marker and routes each accepted word to one of four registered lanes.
// Optional feature: define TDM_DEMUX_SYNC_ERR_EN to add the SYNC_ERR output,
// a one-cycle pulse whenever an SOF arrives mid-frame while locked.
module tdm_demux_1x4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IN_VALID,
  input  logic                 IN_SOF,
  input  logic [n-1:0]         IN_DATA,
  output logic [n-1:0]         Y0,
  output logic [n-1:0]         Y1,
  output logic [n-1:0]         Y2,
  output logic [n-1:0]         Y3,
  output logic [NUM_LANES-1:0] V,
  output logic                 FRAME,
  output logic                 LOCKED
`ifdef TDM_DEMUX_SYNC_ERR_EN
  ,
  output logic                 SYNC_ERR
`endif
);

  state_e               state_q;
  logic [n-1:0]         lane_q [NUM_LANES];
  logic [NUM_LANES-1:0] v_q;
  logic                 frame_q;
  logic [SLOT_W-1:0]    slot;

  logic              accept_sof;
  logic              accept_data;
  logic              wr_en;
  logic [SLOT_W-1:0] wr_slot;

  // SOF is accepted in either state; plain words only count once locked.
  always_comb begin
    accept_sof  = IN_VALID & IN_SOF;
    accept_data = IN_VALID & ~IN_SOF & (state_q == StLock);
    wr_en       = accept_sof | accept_data;
    wr_slot     = IN_SOF ? SLOT0 : slot;
  end

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept_data),
    .load1 (accept_sof),
    .slot  (slot)
  );

`ifdef TDM_DEMUX_SYNC_ERR_EN
  logic resync;
  logic sync_err_q;

  // Mid-frame SOF while locked: partial frame abandoned, realign to slot 0.
  always_comb begin
    resync = accept_sof & (state_q == StLock) & (slot != SLOT0);
  end

  // Error pulse registered alongside the V[0] strobe of the resync word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= resync;
    end
  end

  assign SYNC_ERR = sync_err_q;
`endif

  // FSM, lane registers and registered strobes; reset wins over any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHunt;
      v_q     <= '0;
      frame_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      if (accept_sof) begin
        state_q <= StLock;
      end
      v_q     <= wr_en ? slot_onehot(wr_slot) : '0;
      // A resync SOF writes lane 0, so FRAME can only follow a slot-3 data word.
      frame_q <= accept_data & (slot == SLOT3);
      if (wr_en) begin
        lane_q[wr_slot] <= IN_DATA;
      end
    end
  end

  assign Y0     = lane_q[0];
  assign Y1     = lane_q[1];
  assign Y2     = lane_q[2];
  assign Y3     = lane_q[3];
  assign V      = v_q;
  assign FRAME  = frame_q;
  assign LOCKED = (state_q == StLock);

endmodule
